// File: rtl/adder_subtractor_binary_multiword.sv
// ============================================================================
// adder_subtractor_binary_multiword
//
// Purpose:
//   Multi-cycle two's-complement adder/subtractor for wide operands. Each
//   RUN cycle handles one CHUNK_WIDTH-bit slice, least-significant first.
//   The carry (add) or borrow (sub) moves between slices in a register, so
//   the combinational carry chain in any one cycle is only CHUNK_WIDTH bits.
//   The final slice also yields carry_out and signed overflow.
//
// Optional feature (compile-time macro):
//   ADDER_SUBTRACTOR_BINARY_MULTIWORD_SATURATE_EN
//     When defined, an overflowing result is clamped. The clamp is the most
//     positive value when A >= 0, or the most negative value when A < 0.
//     The clamp is applied on the edge that enters DONE, so it adds no
//     latency. carry_out and overflow still report the unclamped operation.
//
// Ports:
//   clock      in   sole clock, rising edge
//   clear_n    in   asynchronous active-low reset
//   in_valid   in   operands/mode valid
//   in_ready   out  block can accept an operation (IDLE)
//   add_sub    in   0: A+B+carry_in, 1: A-B-carry_in
//   carry_in   in   carry in (add) / borrow in (sub)
//   A_in       in   operand A, WORD_WIDTH bits
//   B_in       in   operand B, WORD_WIDTH bits
//   out_valid  out  result valid (DONE)
//   out_ready  in   consumer accepts result
//   sum_out    out  result, WORD_WIDTH bits
//   carry_out  out  carry out (add) / borrow out (sub)
//   overflow   out  signed overflow
// ============================================================================
module adder_subtractor_binary_multiword #(
    parameter int CHUNK_WIDTH = 8,
    parameter int CHUNK_COUNT = 4
) (
    input  logic                                 clock,
    input  logic                                 clear_n,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic                                 add_sub,
    input  logic                                 carry_in,
    input  logic [CHUNK_WIDTH*CHUNK_COUNT-1:0]   A_in,
    input  logic [CHUNK_WIDTH*CHUNK_COUNT-1:0]   B_in,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [CHUNK_WIDTH*CHUNK_COUNT-1:0]   sum_out,
    output logic                                 carry_out,
    output logic                                 overflow
);

    localparam int WORD_WIDTH = CHUNK_WIDTH * CHUNK_COUNT;
    localparam int CNT_W      = (CHUNK_COUNT > 1) ? $clog2(CHUNK_COUNT) : 1;
    localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(CHUNK_COUNT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [WORD_WIDTH-1:0]  a_reg, b_reg;
    logic                   sub_reg;
    logic                   carry_reg;
    logic [CNT_W-1:0]       count_reg;
    logic                   carry_out_reg;
    logic                   overflow_reg;
    logic [CHUNK_WIDTH-1:0] sum_chunk_reg [CHUNK_COUNT];

    logic [CHUNK_WIDTH-1:0] a_chunk [CHUNK_COUNT];
    logic [CHUNK_WIDTH-1:0] b_chunk [CHUNK_COUNT];

    logic [CHUNK_WIDTH-1:0] a_cur, b_cur, s_cur;
    logic [CHUNK_WIDTH:0]   ext_cur;
    logic                   c_cur;
    logic                   ovf_cur;
    logic                   last_chunk;
    logic                   accept;
    logic                   a_msb, b_msb;

    // Slice the registered operands and reassemble the result word.
    generate
        for (genvar gi = 0; gi < CHUNK_COUNT; gi++) begin : g_chunk
            assign a_chunk[gi] = a_reg[gi*CHUNK_WIDTH +: CHUNK_WIDTH];
            assign b_chunk[gi] = b_reg[gi*CHUNK_WIDTH +: CHUNK_WIDTH];
            assign sum_out[gi*CHUNK_WIDTH +: CHUNK_WIDTH] = sum_chunk_reg[gi];
        end
    endgenerate

    assign a_msb = a_reg[WORD_WIDTH-1];
    assign b_msb = b_reg[WORD_WIDTH-1];

    // One slice of arithmetic. The extra top bit of ext_cur is the carry
    // out (add) or the borrow out (sub).
    always_comb begin
        a_cur      = a_chunk[count_reg];
        b_cur      = b_chunk[count_reg];
        last_chunk = (count_reg == LAST_CHUNK);
        if (sub_reg) begin
            ext_cur = {1'b0, a_cur} - {1'b0, b_cur} - {{CHUNK_WIDTH{1'b0}}, carry_reg};
        end else begin
            ext_cur = {1'b0, a_cur} + {1'b0, b_cur} + {{CHUNK_WIDTH{1'b0}}, carry_reg};
        end
        s_cur = ext_cur[CHUNK_WIDTH-1:0];
        c_cur = ext_cur[CHUNK_WIDTH];
        // Overflow is computed from the operand and result signs. This
        // matches carry-into-MSB XOR carry-out-of-MSB, including when a
        // carry or borrow comes in. For an add, overflow needs equal
        // operand signs; for a subtract, it needs different signs.
        // In both cases the result sign must differ from A's sign.
        if (sub_reg) begin
            ovf_cur = (a_msb != b_msb) && (s_cur[CHUNK_WIDTH-1] != a_msb);
        end else begin
            ovf_cur = (a_msb == b_msb) && (s_cur[CHUNK_WIDTH-1] != a_msb);
        end
    end

    // FSM: state register
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM: next state and handshake outputs
    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_chunk) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign accept = in_valid && in_ready;

    // Datapath registers
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            a_reg         <= '0;
            b_reg         <= '0;
            sub_reg       <= 1'b0;
            carry_reg     <= 1'b0;
            count_reg     <= '0;
            carry_out_reg <= 1'b0;
            overflow_reg  <= 1'b0;
            for (int i = 0; i < CHUNK_COUNT; i++) begin
                sum_chunk_reg[i] <= '0;
            end
        end else begin
            if (accept) begin
                a_reg     <= A_in;
                b_reg     <= B_in;
                sub_reg   <= add_sub;
                carry_reg <= carry_in;
                count_reg <= '0;
            end else if (state_reg == RUN) begin
                sum_chunk_reg[count_reg] <= s_cur;
                carry_reg                <= c_cur;
                count_reg                <= count_reg + 1'b1;
                if (last_chunk) begin
                    carry_out_reg <= c_cur;
                    overflow_reg  <= ovf_cur;
`ifdef ADDER_SUBTRACTOR_BINARY_MULTIWORD_SATURATE_EN
                    // Clamp the whole word. This assignment overrides the
                    // slice write above because it comes later.
                    if (ovf_cur) begin
                        for (int i = 0; i < CHUNK_COUNT; i++) begin
                            if (i == CHUNK_COUNT - 1) begin
                                sum_chunk_reg[i] <= a_msb ? {1'b1, {(CHUNK_WIDTH-1){1'b0}}}
                                                          : {1'b0, {(CHUNK_WIDTH-1){1'b1}}};
                            end else begin
                                sum_chunk_reg[i] <= a_msb ? {CHUNK_WIDTH{1'b0}}
                                                          : {CHUNK_WIDTH{1'b1}};
                            end
                        end
                    end
`endif
                end
            end
        end
    end

    assign carry_out = carry_out_reg;
    assign overflow  = overflow_reg;

endmodule

// File: tb/tb_adder_subtractor_binary_multiword.sv
// ============================================================================
// tb_adder_subtractor_binary_multiword
//
// Purpose:
//   Self-checking bench for adder_subtractor_binary_multiword, configured
//   with CHUNK_WIDTH=8 and CHUNK_COUNT=4. Directed operations push their
//   hand-computed results into a queue. A monitor pops one entry per output
//   handshake and compares it with the DUT outputs. Handshake timing,
//   backpressure and reset-abort behaviour are checked inline.
// ============================================================================
module tb_adder_subtractor_binary_multiword;

    localparam int CW = 8;
    localparam int CC = 4;
    localparam int WW = CW * CC;

    logic          clock;
    logic          clear_n;
    logic          in_valid;
    logic          in_ready;
    logic          add_sub;
    logic          carry_in;
    logic [WW-1:0] a_in;
    logic [WW-1:0] b_in;
    logic          out_valid;
    logic          out_ready;
    logic [WW-1:0] sum_out;
    logic          carry_out;
    logic          overflow;

    typedef struct packed {
        logic [WW-1:0] sum;
        logic          cout;
        logic          ovf;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    adder_subtractor_binary_multiword #(
        .CHUNK_WIDTH(CW),
        .CHUNK_COUNT(CC)
    ) dut (
        .clock     (clock),
        .clear_n   (clear_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .add_sub   (add_sub),
        .carry_in  (carry_in),
        .A_in      (a_in),
        .B_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum_out   (sum_out),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string name, input logic [WW-1:0] act, input logic [WW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor: one comparison set per output handshake.
    always @(negedge clock) begin
        if (clear_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got sum 0x%08h expected no result", sum_out);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check_val("sum_out",   sum_out,          e.sum);
                check_val("carry_out", {31'd0, carry_out}, {31'd0, e.cout});
                check_val("overflow",  {31'd0, overflow},  {31'd0, e.ovf});
                $display("result sum=0x%08h cout=%0b ovf=%0b (expected 0x%08h %0b %0b)",
                         sum_out, carry_out, overflow, e.sum, e.cout, e.ovf);
            end
        end
    end

    // Drive one operation and return 1 ns after its accept edge.
    // If push is set, the expected result is queued for the monitor.
    task automatic send(input logic sub, input logic cin, input logic [WW-1:0] a,
                        input logic [WW-1:0] b, input logic [WW-1:0] esum,
                        input logic ecout, input logic eovf, input bit push);
        bit accepted;
        exp_t e;
        accepted = 0;
        if (push) begin
            e.sum  = esum;
            e.cout = ecout;
            e.ovf  = eovf;
            exp_q.push_back(e);
        end
        add_sub  = sub;
        carry_in = cin;
        a_in     = a;
        b_in     = b;
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !accepted; i++) begin
            @(negedge clock);
            if (in_ready) begin
                @(posedge clock);
                #1;
                accepted = 1;
            end
        end
        in_valid = 1'b0;
        a_in     = '1;
        b_in     = '1;
        if (!accepted) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready=0 expected accept within 50 cycles");
        end
        $display("op %s a=0x%08h b=0x%08h cin=%0b", sub ? "sub" : "add", a, b, cin);
    endtask

    // Wait until out_valid is seen at a negedge. Returns the number of
    // negedges waited.
    task automatic wait_valid(output int n);
        n = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            n++;
            if (out_valid) return;
        end
        checks++;
        errors++;
        $display("FAIL done_timeout: got out_valid=0 expected 1 within 50 cycles");
    endtask

    task automatic finish_op();
        int n;
        wait_valid(n);
        @(posedge clock);
        #1;
    endtask

    initial begin
        int n;
        clear_n   = 1'b0;
        in_valid  = 1'b0;
        add_sub   = 1'b0;
        carry_in  = 1'b0;
        a_in      = '0;
        b_in      = '0;
        out_ready = 1'b1;
        #12;
        // Reset state
        check_val("reset_in_ready",  {31'd0, in_ready},  32'd1);
        check_val("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check_val("reset_sum",       sum_out,            32'd0);
        check_val("reset_carry",     {31'd0, carry_out}, 32'd0);
        check_val("reset_overflow",  {31'd0, overflow},  32'd0);
        @(posedge clock);
        #1;
        clear_n = 1'b1;

        // 1: add with wrap. out_valid is seen after the 5th edge, counting
        // the accept edge as the first.
        send(1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1);
        wait_valid(n);
        check_val("latency_edges", n, 32'd4 + 32'd1);
        @(posedge clock);
        #1;
        // 2: subtract with borrow
        send(1'b1, 1'b0, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 1'b0, 1);
        finish_op();
        // 3: positive overflow
`ifdef ADDER_SUBTRACTOR_BINARY_MULTIWORD_SATURATE_EN
        send(1'b0, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1, 1);
`else
        send(1'b0, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1);
`endif
        finish_op();
        // 4: subtract with borrow in; negative overflow
        send(1'b1, 1'b1, 32'h0000_0010, 32'h0000_0005, 32'h0000_000A, 1'b0, 1'b0, 1);
        finish_op();
`ifdef ADDER_SUBTRACTOR_BINARY_MULTIWORD_SATURATE_EN
        send(1'b1, 1'b0, 32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1);
`else
        send(1'b1, 1'b0, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1, 1);
`endif
        finish_op();
        // Extra patterns: carry-in add, small negative difference, MIN+MIN
        send(1'b0, 1'b1, 32'h1234_5678, 32'h1111_1111, 32'h2345_678A, 1'b0, 1'b0, 1);
        finish_op();
        send(1'b1, 1'b0, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b1, 1'b0, 1);
        finish_op();
`ifdef ADDER_SUBTRACTOR_BINARY_MULTIWORD_SATURATE_EN
        send(1'b0, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 1);
`else
        send(1'b0, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1, 1);
`endif
        finish_op();

        // 5: backpressure in DONE, then back-to-back operation
        out_ready = 1'b0;
        send(1'b0, 1'b0, 32'h00FF_00FF, 32'h0101_0101, 32'h0200_0200, 1'b0, 1'b0, 1);
        wait_valid(n);
        for (int i = 0; i < 5; i++) begin
            check_val("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check_val("bp_in_ready",  {31'd0, in_ready},  32'd0);
            check_val("bp_sum_hold",  sum_out,            32'h0200_0200);
            @(negedge clock);
        end
        @(posedge clock);
        #1;
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        check_val("bp_in_ready_after", {31'd0, in_ready}, 32'd1);
        send(1'b0, 1'b0, 32'h0000_00FF, 32'h0000_0001, 32'h0000_0100, 1'b0, 1'b0, 1);
        finish_op();

        // 6: asynchronous reset in the 2nd RUN cycle aborts the operation
        send(1'b0, 1'b0, 32'h0000_0001, 32'h0000_0002, 32'h0, 1'b0, 1'b0, 0);
        @(posedge clock);
        #2;
        clear_n = 1'b0;
        #1;
        check_val("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check_val("abort_sum",       sum_out,            32'd0);
        check_val("abort_carry",     {31'd0, carry_out}, 32'd0);
        check_val("abort_overflow",  {31'd0, overflow},  32'd0);
        check_val("abort_in_ready",  {31'd0, in_ready},  32'd1);
        @(posedge clock);
        #3;
        clear_n = 1'b1;
        send(1'b0, 1'b0, 32'h0000_0003, 32'h0000_0004, 32'h0000_0007, 1'b0, 1'b0, 1);
        finish_op();

        repeat (3) @(posedge clock);
        #1;
        check_val("queue_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000 ns");
        $fatal(1);
    end

endmodule

// File: doc/adder_subtractor_binary_multiword.md
Name: adder_subtractor_binary_multiword

Overview:
Multi-cycle binary integer adder/subtractor for wide operands. It processes CHUNK_WIDTH bits per cycle over CHUNK_COUNT cycles and chains the carry or borrow in a register between cycles. This gives wide arithmetic with a short carry chain per cycle. Valid/ready handshakes on input and output let it sit in a pipelined datapath; it also reports carry/borrow and signed overflow.

Parameters:
CHUNK_WIDTH, 8, bits computed per cycle; must be >= 1.
CHUNK_COUNT, 4, chunks per word; must be >= 1. WORD_WIDTH = CHUNK_WIDTH*CHUNK_COUNT (localparam).

Ports:
clock  input  1  sole clock, rising edge.
clear_n  input  1  asynchronous, active-low reset.
in_valid  input  1  operands and mode are valid.
in_ready  output  1  block accepts a new operation.
add_sub  input  1  0 selects A+B+carry_in; 1 selects A-B-carry_in.
carry_in  input  1  carry in (add) or borrow in (sub).
A_in  input  WORD_WIDTH  operand A, two's complement.
B_in  input  WORD_WIDTH  operand B, two's complement.
out_valid  output  1  result is valid.
out_ready  input  1  consumer accepts the result.
sum_out  output  WORD_WIDTH  result.
carry_out  output  1  carry out (add) or borrow out (sub; 1 when A < B+carry_in unsigned).
overflow  output  1  signed result is not representable in WORD_WIDTH bits.

Behaviour:
- Reset is asynchronous and active-low, one clock. While clear_n=0: state=IDLE, in_ready=1, out_valid=0, sum_out=0, carry_out=0, overflow=0, internal chunk counter and carry register=0.
- FSM IDLE: in_ready=1. When in_valid&in_ready, register A_in, B_in, add_sub and carry_in; load the carry register with carry_in; set counter=0; go to RUN.
- FSM RUN: in_ready=0. Each cycle, chunk k = counter.
  - Add: {c,s} = A[k] + B[k] + carry.
  - Sub: {b,s} = A[k] - B[k] - borrow, computed per chunk in CHUNK_WIDTH+1 bits.
  - Write s into sum_out chunk k and update the carry register.
  - On the last chunk (counter=CHUNK_COUNT-1), compute carry_out and overflow, then go to DONE.
- Overflow is carry into the MSB XOR carry out of the MSB, evaluated on the final chunk. It equals the condition that the exact signed A±B±cin falls outside [-2^(WORD_WIDTH-1), 2^(WORD_WIDTH-1)-1].
- FSM DONE: out_valid=1, in_ready=0. sum_out, carry_out and overflow are held stable until out_ready=1. On out_valid&out_ready, go to IDLE.
- There is no same-cycle turnaround: in_ready rises on the cycle after the output handshake.
- Latency: the accept edge is followed by CHUNK_COUNT RUN cycles. out_valid asserts CHUNK_COUNT+1 edges after acceptance. Maximum throughput is one operation per CHUNK_COUNT+2 cycles.
- Boundaries:
  - CHUNK_COUNT=1 gives one RUN cycle.
  - in_valid during RUN or DONE is ignored; the source must hold it.
  - out_ready high before DONE has no effect.
  - sum_out is undefined-but-deterministic while not out_valid; verification checks it only when out_valid=1.
  - clear_n low mid-RUN or mid-DONE aborts the operation: all outputs take reset values and the partial result is discarded.
  - Operands registered at accept are immune to later A_in/B_in changes.

Optional Feature:
- Macro ADDER_SUBTRACTOR_BINARY_MULTIWORD_SATURATE_EN.
- When defined: if overflow=1 at DONE, sum_out is replaced by the saturation limit. The limit is 2^(WORD_WIDTH-1)-1 when A is non-negative, or -2^(WORD_WIDTH-1) when A is negative. carry_out and overflow are reported unchanged. The replacement is applied on the DONE entry edge with no added latency.
- When undefined: sum_out is the wrapped result, and the saturation logic is not present.

Test Plan:
All scenarios use CHUNK_WIDTH=8 and CHUNK_COUNT=4.
1. Add 0xFFFFFFFF + 0x00000001, cin=0 -> sum 0x00000000, carry_out=1, overflow=0, out_valid on the 5th edge after accept.
2. Sub 0x00000000 - 0x00000001, cin=0 -> sum 0xFFFFFFFF, carry_out(borrow)=1, overflow=0.
3. Add 0x7FFFFFFF + 0x00000001 -> sum 0x80000000, overflow=1, carry_out=0. With SATURATE_EN -> sum 0x7FFFFFFF, overflow=1.
4. Sub 0x00000010 - 0x00000005, cin=1 -> sum 0x0000000A, carry_out=0, overflow=0. Sub 0x80000000 - 0x00000001 -> 0x7FFFFFFF, overflow=1.
5. Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid stays 1, outputs stable, in_ready=0. Then out_ready=1 -> in_ready=1 next cycle, and a back-to-back second operation completes correctly.
6. Reset mid-op: assert clear_n=0 asynchronously on the 2nd RUN cycle -> out_valid=0, sum_out=0, carry_out=0 immediately. After release, in_ready=1, and a new add 3+4 gives 7.
